fazyrv_mem_arb: RTL and testbench
=================================

# fazyrv_mem_arb

Two-port to one-port memory arbiter that shares a single Wishbone classic master port between the core's instruction-fetch requester and its load/store requester. It sits between the control/datapath and the system bus. It replaces the separate imem/dmem buses when the SoC exposes only one memory port. An optional bus timeout produces an abort pulse that the core can feed into its abort input.

## Interface
- `ADR_WIDTH`, 32, width of all addresses.
- `REG_WIDTH`, 32, data width; byte-select width is `REG_WIDTH/8`.
- `TIMEOUT`, 0, cycles to wait for `wb_ack_i` before giving up; 0 disables the timeout logic.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_in` in 1: reset, asynchronous, active-low.
- `imem_stb_i` in 1: fetch request; held high until `imem_ack_o`.
- `imem_adr_i` in `ADR_WIDTH`: fetch address.
- `imem_ack_o` out 1: fetch done.
- `imem_rdat_o` out `REG_WIDTH`: fetched word.
- `dmem_stb_i` in 1: data request; held high until `dmem_ack_o`.
- `dmem_we_i` in 1: store when high.
- `dmem_be_i` in `REG_WIDTH/8`: byte enables.
- `dmem_adr_i` in `ADR_WIDTH`: data address.
- `dmem_wdat_i` in `REG_WIDTH`: store data.
- `dmem_ack_o` out 1: data access done.
- `dmem_rdat_o` out `REG_WIDTH`: load data.
- `wb_cyc_o` out 1: bus cycle.
- `wb_stb_o` out 1: bus strobe.
- `wb_we_o` out 1: bus write enable.
- `wb_sel_o` out `REG_WIDTH/8`: bus byte select.
- `wb_adr_o` out `ADR_WIDTH`: bus address.
- `wb_dat_o` out `REG_WIDTH`: bus write data.
- `wb_dat_i` in `REG_WIDTH`: bus read data.
- `wb_ack_i` in 1: bus acknowledge.
- `tmo_o` out 1: one-cycle timeout pulse.

## Operation
- The FSM has three states: `IDLE`, `BUSY_I`, `BUSY_D`. There is also a 1-bit `last_d_r` register, set when the last grant went to data.
- In `IDLE`:
  - `imem_stb_i` alone → `BUSY_I`.
  - `dmem_stb_i` alone → `BUSY_D`.
  - Both high → round-robin: grant data if `last_d_r==0`, otherwise grant instruction.
  - Neither high → stay in `IDLE`.
- On grant, register the bus outputs:
  - `wb_cyc_o=wb_stb_o=1`.
  - Instruction grant: `wb_we_o=0`, `wb_sel_o` all ones, `wb_adr_o=imem_adr_i`, `wb_dat_o` unchanged.
  - Data grant: `wb_we_o=dmem_we_i`, `wb_sel_o=dmem_be_i`, `wb_adr_o=dmem_adr_i`, `wb_dat_o=dmem_wdat_i`.
  - Update `last_d_r`.
- Address, select, write-enable and data stay frozen for the whole bus cycle. Requester inputs are not re-sampled while busy.
- `BUSY_x` with `wb_ack_i=1` → `IDLE`; `wb_cyc_o` and `wb_stb_o` clear on the next edge.
- Acks and read data are combinational pass-throughs:
  - `imem_ack_o = wb_ack_i & (state==BUSY_I)`, same pattern for `dmem_ack_o`.
  - `imem_rdat_o = dmem_rdat_o = wb_dat_i` while an ack is asserted, otherwise 0.
- `wb_ack_i` in `IDLE` is ignored.
- Timeout applies only when `TIMEOUT>0`:
  - The wait counter (`$clog2(TIMEOUT+1)` bits) clears on grant and increments each busy cycle without an ack.
  - When it reaches `TIMEOUT-1` with no ack: pulse `tmo_o` and the owning requester's ack for one cycle, force the returned rdat to 0, and go to `IDLE`, dropping `cyc`/`stb`.
  - Ack and timeout in the same cycle: the ack wins and `tmo_o` stays 0.
- A requester that drops `stb` while busy is a protocol violation. The arbiter ignores it and completes the bus cycle; no ack is routed anywhere except through the formula above.

## Timing
- Reset values: state `IDLE`, `last_d_r=1` (instruction wins the first tie), counter 0, every registered output 0.
- Reset mid-transaction drops `wb_cyc_o` asynchronously. Any later `wb_ack_i` is ignored.
- Grant latency: a request seen in `IDLE` at edge n puts `wb_cyc_o`/`wb_stb_o` high after edge n.
- Ack latency: 0 cycles from `wb_ack_i`.
- Best-case throughput: one access per 2 cycles (grant cycle + ack cycle). The `IDLE` cycle after each ack absorbs the requester's stb deassertion, so the same strobe is never granted twice.
- `tmo_o` is high exactly one cycle, in the `TIMEOUT`-th busy cycle.

## Test plan
- Reset, then `imem_stb_i=1` with `imem_adr_i=0x100`:
  - Next cycle: `wb_cyc_o=1`, `wb_adr_o=0x100`, `wb_we_o=0`, `wb_sel_o=0xF`.
  - Slave acks 2 cycles later with `0xDEADBEEF` → `imem_ack_o=1` and `imem_rdat_o=0xDEADBEEF` in that same cycle; `wb_cyc_o=0` next cycle.
- Store: `dmem_we_i=1`, `dmem_be_i=0x3`, `dmem_adr_i=0x2000`, `dmem_wdat_i=0x1234` → bus shows those exact values. Ack → `dmem_ack_o=1`, `imem_ack_o=0`.
- Both strobes high from reset, each held until its ack → grant order I, D, I, D. `dmem_ack_o` never pulses during a `BUSY_I` transaction.
- `TIMEOUT=4` with no ack → `tmo_o=1` and `imem_ack_o=1` with rdat 0 in busy cycle 4, then `wb_cyc_o=0`. Variant: `wb_ack_i` arrives in cycle 4 → normal ack, `tmo_o=0`.
- Assert `rst_in=0` while `BUSY_D` → `wb_cyc_o=0` before the next clock edge. After release, a stray `wb_ack_i` produces no requester ack.

Source files
------------

// File: rtl/fazyrv_mem_arb.sv
// fazyrv_mem_arb: shares one Wishbone classic master port between the
// instruction-fetch and load/store requesters, with round-robin tie-breaking
// and an optional bus timeout that aborts a stalled access.
//
// state  | meaning
// IDLE   | no bus cycle; requests are sampled and one is granted
// BUSY_I | bus cycle owned by instruction fetch
// BUSY_D | bus cycle owned by load/store
module fazyrv_mem_arb #(
  parameter int ADR_WIDTH = 32,
  parameter int REG_WIDTH = 32,
  parameter int TIMEOUT   = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_in,

  input  logic                   imem_stb_i,
  input  logic [ADR_WIDTH-1:0]   imem_adr_i,
  output logic                   imem_ack_o,
  output logic [REG_WIDTH-1:0]   imem_rdat_o,

  input  logic                   dmem_stb_i,
  input  logic                   dmem_we_i,
  input  logic [REG_WIDTH/8-1:0] dmem_be_i,
  input  logic [ADR_WIDTH-1:0]   dmem_adr_i,
  input  logic [REG_WIDTH-1:0]   dmem_wdat_i,
  output logic                   dmem_ack_o,
  output logic [REG_WIDTH-1:0]   dmem_rdat_o,

  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  output logic                   wb_we_o,
  output logic [REG_WIDTH/8-1:0] wb_sel_o,
  output logic [ADR_WIDTH-1:0]   wb_adr_o,
  output logic [REG_WIDTH-1:0]   wb_dat_o,
  input  logic [REG_WIDTH-1:0]   wb_dat_i,
  input  logic                   wb_ack_i,

  output logic                   tmo_o
);

  localparam int SEL_W  = REG_WIDTH / 8;
  // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 last_d_q, last_d_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [ADR_WIDTH-1:0] adr_q, adr_d;
  logic [REG_WIDTH-1:0] dat_q, dat_d;

  logic busy_i, busy_d, busy;
  logic bus_ack, tmo, done;
  logic grant_d;

  // Completion decode: a real ack always beats a timeout in the same cycle.
  always_comb begin
    busy_i  = (state_q == BUSY_I);
    busy_d  = (state_q == BUSY_D);
    busy    = busy_i | busy_d;
    bus_ack = busy & wb_ack_i;
    tmo     = TMO_EN & busy & ~wb_ack_i & (cnt_q == CNT_LAST);
    done    = bus_ack | tmo;
  end

  assign imem_ack_o  = busy_i & done;
  assign dmem_ack_o  = busy_d & done;
  // Read data is only passed through on a genuine ack; an aborted access returns 0.
  assign imem_rdat_o = bus_ack ? wb_dat_i : '0;
  assign dmem_rdat_o = bus_ack ? wb_dat_i : '0;
  assign tmo_o       = tmo;

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_sel_o = sel_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;

  // Next-state: arbitrate in IDLE, freeze bus fields while busy, release on ack or timeout.
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    sel_d    = sel_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    grant_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (imem_stb_i | dmem_stb_i) begin
          // On a tie, data wins only if the previous grant was not data.
          grant_d  = dmem_stb_i & (~imem_stb_i | ~last_d_q);
          state_d  = grant_d ? BUSY_D : BUSY_I;
          last_d_d = grant_d;
          cnt_d    = '0;
          cyc_d    = 1'b1;
          if (grant_d) begin
            we_d  = dmem_we_i;
            sel_d = dmem_be_i;
            adr_d = dmem_adr_i;
            dat_d = dmem_wdat_i;
          end else begin
            we_d  = 1'b0;
            sel_d = '1;
            adr_d = imem_adr_i;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (done) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
        end else if (TMO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // State and bus-output registers; reset leaves instruction fetch winning the first tie.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      cnt_q    <= '0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
    end
  end

endmodule

// File: tb/tb_fazyrv_mem_arb.sv
// Testbench for fazyrv_mem_arb: directed scenarios followed by randomized
// transactions, checked against a transaction-level reference model.
module tb_fazyrv_mem_arb;

  localparam int AW  = 32;
  localparam int RW  = 32;
  localparam int SW  = RW / 8;
  localparam int TMO = 4;

  logic          clk_i = 1'b0;
  logic          rst_in;
  logic          imem_stb_i;
  logic [AW-1:0] imem_adr_i;
  logic          imem_ack_o;
  logic [RW-1:0] imem_rdat_o;
  logic          dmem_stb_i;
  logic          dmem_we_i;
  logic [SW-1:0] dmem_be_i;
  logic [AW-1:0] dmem_adr_i;
  logic [RW-1:0] dmem_wdat_i;
  logic          dmem_ack_o;
  logic [RW-1:0] dmem_rdat_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [SW-1:0] wb_sel_o;
  logic [AW-1:0] wb_adr_o;
  logic [RW-1:0] wb_dat_o;
  logic [RW-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          tmo_o;

  always #5 clk_i = ~clk_i;

  fazyrv_mem_arb #(.ADR_WIDTH(AW), .REG_WIDTH(RW), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_in(rst_in),
    .imem_stb_i(imem_stb_i), .imem_adr_i(imem_adr_i),
    .imem_ack_o(imem_ack_o), .imem_rdat_o(imem_rdat_o),
    .dmem_stb_i(dmem_stb_i), .dmem_we_i(dmem_we_i), .dmem_be_i(dmem_be_i),
    .dmem_adr_i(dmem_adr_i), .dmem_wdat_i(dmem_wdat_i),
    .dmem_ack_o(dmem_ack_o), .dmem_rdat_o(dmem_rdat_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .tmo_o(tmo_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Requester-side model: pending requests, their fields, and arbitration history.
  bit            pi, pd, just_i, just_d, last_d;
  logic [AW-1:0] ri_adr, rd_adr;
  logic [RW-1:0] rd_wdat, exp_dat;
  logic          rd_we;
  logic [SW-1:0] rd_be;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic drive_req();
    imem_stb_i  = pi;
    imem_adr_i  = ri_adr;
    dmem_stb_i  = pd;
    dmem_we_i   = rd_we;
    dmem_be_i   = rd_be;
    dmem_adr_i  = rd_adr;
    dmem_wdat_i = rd_wdat;
  endtask

  // One arbitration round: an IDLE cycle, then (if anything is pending) the
  // granted access until the slave acks in busy cycle 'lat' or the timeout fires.
  task automatic do_txn(input int lat, input logic [31:0] ack_dat);
    bit            g_d, hit, to;
    logic [AW-1:0] e_adr;
    logic          e_we;
    logic [SW-1:0] e_sel;
    @(negedge clk_i);
    drive_req();
    wb_ack_i = 1'($urandom);
    wb_dat_i = $urandom;
    #1;
    chk("idle_cyc", 32'(wb_cyc_o), 0);
    chk("idle_stb", 32'(wb_stb_o), 0);
    chk("idle_iack", 32'(imem_ack_o), 0);
    chk("idle_dack", 32'(dmem_ack_o), 0);
    chk("idle_tmo", 32'(tmo_o), 0);
    just_i = 0;
    just_d = 0;
    if (!pi && !pd) return;
    g_d    = pd && (!pi || !last_d);
    last_d = g_d;
    e_we   = g_d ? rd_we : 1'b0;
    e_sel  = g_d ? rd_be : '1;
    e_adr  = g_d ? rd_adr : ri_adr;
    if (g_d) exp_dat = rd_wdat;
    for (int k = 1; k <= TMO + 2; k++) begin
      @(negedge clk_i);
      drive_req();
      hit      = (k == lat);
      to       = !hit && (k == TMO);
      wb_ack_i = hit;
      wb_dat_i = hit ? ack_dat : $urandom;
      #1;
      chk("busy_cyc", 32'(wb_cyc_o), 1);
      chk("busy_stb", 32'(wb_stb_o), 1);
      chk("busy_we", 32'(wb_we_o), 32'(e_we));
      chk("busy_sel", 32'(wb_sel_o), 32'(e_sel));
      chk("busy_adr", wb_adr_o, e_adr);
      chk("busy_dat", wb_dat_o, exp_dat);
      chk("busy_iack", 32'(imem_ack_o), 32'(!g_d && (hit || to)));
      chk("busy_dack", 32'(dmem_ack_o), 32'(g_d && (hit || to)));
      chk("busy_tmo", 32'(tmo_o), 32'(to));
      chk("busy_irdat", imem_rdat_o, hit ? ack_dat : 32'h0);
      chk("busy_drdat", dmem_rdat_o, hit ? ack_dat : 32'h0);
      if (hit || to) begin
        if (g_d) begin pd = 0; just_d = 1; end
        else     begin pi = 0; just_i = 1; end
        break;
      end
    end
  endtask

  initial begin
    pi = 0; pd = 0; just_i = 0; just_d = 0; last_d = 1;
    ri_adr = '0; rd_adr = '0; rd_wdat = '0; rd_we = 0; rd_be = '0; exp_dat = '0;
    drive_req();
    wb_ack_i = 0;
    wb_dat_i = '0;
    rst_in = 1'b1;
    #2 rst_in = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_cyc", 32'(wb_cyc_o), 0);
    chk("rst_stb", 32'(wb_stb_o), 0);
    chk("rst_we", 32'(wb_we_o), 0);
    chk("rst_sel", 32'(wb_sel_o), 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_tmo", 32'(tmo_o), 0);
    chk("rst_iack", 32'(imem_ack_o), 0);
    chk("rst_dack", 32'(dmem_ack_o), 0);
    @(negedge clk_i);
    rst_in = 1'b1;

    // Fetch from 0x100, slave answers in busy cycle 2.
    pi = 1; ri_adr = 32'h100;
    do_txn(2, 32'hDEADBEEF);

    // Store with partial byte enables.
    pd = 1; rd_we = 1; rd_be = 4'h3; rd_adr = 32'h2000; rd_wdat = 32'h1234;
    do_txn(1, 32'h5555AAAA);

    // Fetch after the store: write data on the bus must remain the store's.
    pi = 1; ri_adr = 32'h104;
    do_txn(3, 32'h0BADF00D);

    // Reset while the bus is owned by data.
    pd = 1; rd_we = 1; rd_be = 4'hC; rd_adr = 32'h3000; rd_wdat = 32'hCAFE0000;
    @(negedge clk_i);
    drive_req();
    wb_ack_i = 0;
    #1;
    chk("mid_idle_cyc", 32'(wb_cyc_o), 0);
    @(negedge clk_i);
    #1;
    chk("mid_busy_cyc", 32'(wb_cyc_o), 1);
    rst_in = 1'b0;
    #1;
    chk("mid_async_cyc", 32'(wb_cyc_o), 0);
    chk("mid_async_stb", 32'(wb_stb_o), 0);
    pd = 0;
    drive_req();
    last_d = 1; exp_dat = '0; just_i = 0; just_d = 0;
    @(negedge clk_i);
    rst_in = 1'b1;
    @(negedge clk_i);
    wb_ack_i = 1;
    wb_dat_i = 32'h77777777;
    #1;
    chk("stray_iack", 32'(imem_ack_o), 0);
    chk("stray_dack", 32'(dmem_ack_o), 0);
    chk("stray_irdat", imem_rdat_o, 0);
    chk("stray_cyc", 32'(wb_cyc_o), 0);
    wb_ack_i = 0;

    // Both requesting from reset: I, D, then a fresh tie resolves to I, then D.
    pi = 1; ri_adr = 32'h200;
    pd = 1; rd_we = 0; rd_be = 4'hF; rd_adr = 32'h4000; rd_wdat = 32'h11112222;
    do_txn(1, 32'hA0000001);
    do_txn(2, 32'hA0000002);
    do_txn(1, 32'h0);
    pi = 1; ri_adr = 32'h204;
    pd = 1; rd_adr = 32'h4004;
    do_txn(1, 32'hA0000003);
    do_txn(1, 32'hA0000004);

    // Timeout on a fetch, then an ack landing exactly in the last allowed cycle.
    pi = 1; ri_adr = 32'h300;
    do_txn(TMO + 1, 32'hFFFFFFFF);
    do_txn(1, 32'h0);
    pi = 1; ri_adr = 32'h304;
    do_txn(TMO, 32'h12345678);
    pd = 1; rd_we = 1; rd_be = 4'h1; rd_adr = 32'h5000; rd_wdat = 32'h000000AB;
    do_txn(TMO + 2, 32'hFFFFFFFF);

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      if (!pi && !just_i && $urandom_range(0, 1) == 1) begin
        pi = 1; ri_adr = $urandom;
      end
      if (!pd && !just_d && $urandom_range(0, 1) == 1) begin
        pd = 1; rd_we = 1'($urandom); rd_be = 4'($urandom);
        rd_adr = $urandom; rd_wdat = $urandom;
      end
      do_txn($urandom_range(1, TMO + 2), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
